// File: rtl/std_mem_d1_reader.sv
// -----------------------------------------------------------------------------
// std_mem_d1_reader
//
// Sequential read initiator for a std_mem_d1 memory port. A start request
// latches a first address and a word count, then the block walks consecutive
// addresses (wrapping at SIZE) over the memory's combinational read path and
// delivers each word on a registered ready/valid stream. A one-cycle done
// pulse follows acceptance of the final word.
//
// Ports
//   clk            clock, rising edge
//   reset_n        asynchronous active-low reset
//   go             start request, sampled only while idle
//   start_idx      first address (values >= SIZE start at 0)
//   count          number of words, 0..SIZE (larger values clamp to SIZE)
//   mem_addr0      read address to the memory
//   mem_read_data  read data from the memory, combinational in mem_addr0
//   out_data       stream data (registered)
//   out_valid      stream valid (registered)
//   out_ready      stream ready from the consumer
//   done           one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module std_mem_d1_reader #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic [IDX_SIZE-1:0] start_idx,
    input  logic [IDX_SIZE:0]   count,
    output logic [IDX_SIZE-1:0] mem_addr0,
    input  logic [WIDTH-1:0]    mem_read_data,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_SIZE:0]   SIZE_C = (IDX_SIZE+1)'(SIZE);
    localparam logic [IDX_SIZE-1:0] LAST_C = IDX_SIZE'(SIZE - 1);

    logic [1:0]          state_q, state_d;
    logic [IDX_SIZE-1:0] addr_q, addr_d;
    logic [IDX_SIZE:0]   remaining_q, remaining_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic                slot_free;
    logic [IDX_SIZE-1:0] start_fixed;
    logic [IDX_SIZE:0]   count_fixed;

    // The output register can take a new word when it is empty or its
    // current word is being accepted this cycle.
    assign slot_free   = !valid_q || out_ready;

    // Out-of-range start addresses begin at 0; oversize counts read the
    // whole memory once.
    assign start_fixed = ({1'b0, start_idx} >= SIZE_C) ? '0 : start_idx;
    assign count_fixed = (count > SIZE_C) ? SIZE_C : count;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    addr_d      = start_fixed;
                    remaining_d = count_fixed;
                    state_d     = (count_fixed == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                // A stalled slot freezes every register so no word is
                // dropped or issued twice.
                if (slot_free) begin
                    if (remaining_q != '0) begin
                        data_d      = mem_read_data;
                        valid_d     = 1'b1;
                        remaining_d = remaining_q - (IDX_SIZE+1)'(1);
                        addr_d      = (addr_q == LAST_C) ? '0 : addr_q + IDX_SIZE'(1);
                    end else begin
                        // Last word has just been accepted (or none was due).
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // done is registered so it is high exactly while the state is DONE.
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign mem_addr0 = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_std_mem_d1_reader.sv
// -----------------------------------------------------------------------------
// Testbench for std_mem_d1_reader. Two instances share the clock and reset:
// A uses SIZE=16, B uses SIZE=12 (both IDX_SIZE=4), each attached to its own
// combinational memory array. Expected streams are built as a list of words
// mem[(start+k) % SIZE]; timing expectations come from the word count and
// the number of stalled cycles.
// -----------------------------------------------------------------------------
module tb_std_mem_d1_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        go_a, go_b;
    logic [3:0]  start_idx;
    logic [4:0]  count;
    logic        out_ready;

    logic [3:0]  addr_a, addr_b;
    logic [31:0] rd_a, rd_b, od_a, od_b;
    logic        ov_a, ov_b, dn_a, dn_b;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];

    assign rd_a = mem_a[addr_a];
    assign rd_b = mem_b[addr_b];

    int nvec  = 0;
    int nfail = 0;

    std_mem_d1_reader #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .go(go_a), .start_idx(start_idx),
        .count(count), .mem_addr0(addr_a), .mem_read_data(rd_a),
        .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready), .done(dn_a)
    );

    std_mem_d1_reader #(.WIDTH(32), .SIZE(12), .IDX_SIZE(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .go(go_b), .start_idx(start_idx),
        .count(count), .mem_addr0(addr_b), .mem_read_data(rd_b),
        .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready), .done(dn_b)
    );

    // mode 0: always ready, 1: random (mostly ready), 2: fixed toggle pattern
    function automatic bit ready_val(input int mode, input int i);
        logic [7:0] pat;
        pat = 8'b1110_1001;  // i=0..7 -> 1,0,0,1,0,1,1,1
        if (mode == 0) return 1'b1;
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (i < 8) return pat[i];
        return 1'b1;
    endfunction

    // One complete transfer on instance sel (0=A, 1=B). Called at a negedge;
    // returns at the negedge after the block is back in IDLE.
    task automatic run(input bit sel, input int s, input int c, input int mode, input bit hold_go);
        int          sz, es, n, idx, stalls, got, target;
        logic [31:0] exp_q[$];
        bit          prev_stall, seen_done;
        logic [31:0] prev_data, w, od;
        logic        v, d;
        logic [3:0]  ad;

        sz = sel ? 12 : 16;
        es = (s >= sz) ? 0 : s;
        n  = (c > sz) ? sz : c;
        for (int k = 0; k < n; k++)
            exp_q.push_back(sel ? mem_b[(es + k) % sz] : mem_a[(es + k) % sz]);

        start_idx = s[3:0];
        count     = c[4:0];
        go_a      = !sel;
        go_b      = sel;
        out_ready = ready_val(mode, 0);
        @(posedge clk);
        @(negedge clk);
        if (!hold_go) begin
            go_a = 1'b0;
            go_b = 1'b0;
        end

        ad = sel ? addr_b : addr_a;
        v  = sel ? ov_b : ov_a;
        nvec++;
        if (ad !== es[3:0]) begin
            nfail++;
            $display("FAIL start_addr sel=%0d s=%0d: got %0d want %0d", sel, s, ad, es);
        end
        nvec++;
        if (v !== 1'b0) begin
            nfail++;
            $display("FAIL early_valid sel=%0d: out_valid=%b right after go, want 0", sel, v);
        end

        idx = 0; stalls = 0; got = 0; prev_stall = 0; seen_done = 0; prev_data = '0;
        while (!seen_done && idx < 200) begin
            v  = sel ? ov_b : ov_a;
            d  = sel ? dn_b : dn_a;
            od = sel ? od_b : od_a;
            ad = sel ? addr_b : addr_a;

            nvec++;
            if (int'(ad) >= sz) begin
                nfail++;
                $display("FAIL addr_range sel=%0d idx=%0d: addr %0d, want < %0d", sel, idx, ad, sz);
            end
            if (prev_stall) begin
                nvec++;
                if (v !== 1'b1 || od !== prev_data) begin
                    nfail++;
                    $display("FAIL stall_hold sel=%0d idx=%0d: valid=%b data=%0h, want 1/%0h",
                             sel, idx, v, od, prev_data);
                end
            end
            target = (n == 0) ? 0 : n + 1 + stalls;
            nvec++;
            if (d !== ((exp_q.size() == 0 && idx == target) ? 1'b1 : 1'b0)) begin
                nfail++;
                $display("FAIL done_timing sel=%0d idx=%0d: done=%b, want done only at idx %0d",
                         sel, idx, d, target);
            end

            if (d === 1'b1) begin
                seen_done = 1;
                nvec++;
                if (v !== 1'b0) begin
                    nfail++;
                    $display("FAIL done_valid sel=%0d: out_valid=%b during done, want 0", sel, v);
                end
            end else begin
                out_ready = ready_val(mode, idx + 1);
                if (v === 1'b1 && exp_q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL extra_word sel=%0d idx=%0d: valid with data %0h, want no word",
                             sel, idx, od);
                end
                if (v === 1'b1 && out_ready && exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    got++;
                    nvec++;
                    if (od !== w) begin
                        nfail++;
                        $display("FAIL word sel=%0d #%0d: got %0h want %0h", sel, got, od, w);
                    end
                end
                prev_stall = (v === 1'b1) && !out_ready;
                if (prev_stall) stalls++;
                prev_data = od;
                @(negedge clk);
                idx++;
            end
        end

        if (!seen_done) begin
            nvec++;
            nfail++;
            $display("FAIL timeout sel=%0d s=%0d c=%0d: no done in 200 cycles", sel, s, c);
        end
        nvec++;
        if (got != n) begin
            nfail++;
            $display("FAIL word_count sel=%0d: accepted %0d want %0d", sel, got, n);
        end

        @(negedge clk);
        v = sel ? ov_b : ov_a;
        d = sel ? dn_b : dn_a;
        nvec++;
        if (v !== 1'b0 || d !== 1'b0) begin
            nfail++;
            $display("FAIL after_done sel=%0d: valid=%b done=%b, want 0/0", sel, v, d);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; go_a = 1'b0; go_b = 1'b0;
        start_idx = '0; count = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if (od_a !== 32'd0 || ov_a !== 1'b0 || dn_a !== 1'b0 || addr_a !== 4'd0) begin
            nfail++;
            $display("FAIL reset_a: data=%0h valid=%b done=%b addr=%0d, want all 0", od_a, ov_a, dn_a, addr_a);
        end
        nvec++;
        if (od_b !== 32'd0 || ov_b !== 1'b0 || dn_b !== 1'b0 || addr_b !== 4'd0) begin
            nfail++;
            $display("FAIL reset_b: data=%0h valid=%b done=%b addr=%0d, want all 0", od_b, ov_b, dn_b, addr_b);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run(0, 2, 4, 0, 0);
    endtask

    task automatic test_wrap();
        run(0, 14, 4, 0, 0);
        run(1, 10, 3, 0, 0);
    endtask

    task automatic test_backpressure();
        run(0, 0, 5, 2, 0);
    endtask

    task automatic test_zero_clamp();
        run(0, 5, 0, 0, 0);
        run(0, 0, 31, 0, 0);
        run(1, 13, 4, 0, 0);
        run(1, 3, 20, 0, 0);
    endtask

    task automatic test_reset_mid();
        int hs, guard;
        go_a = 1'b1; start_idx = 4'd3; count = 5'd8; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go_a = 1'b0;
        hs = 0; guard = 0;
        while (hs < 2 && guard < 50) begin
            if (ov_a === 1'b1 && out_ready) hs++;
            if (hs < 2) @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #2;
        nvec++;
        if (ov_a !== 1'b1) begin
            nfail++;
            $display("FAIL mid_stream: valid=%b before reset, want 1", ov_a);
        end
        reset_n = 1'b0;
        #1;
        nvec++;
        if (ov_a !== 1'b0 || od_a !== 32'd0 || dn_a !== 1'b0 || addr_a !== 4'd0) begin
            nfail++;
            $display("FAIL async_reset: valid=%b data=%0h done=%b addr=%0d, want all 0",
                     ov_a, od_a, dn_a, addr_a);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(0, 9, 3, 0, 0);
    endtask

    task automatic test_back_to_back();
        run(0, 6, 3, 0, 1);
        run(0, 6, 3, 0, 1);
        go_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            nvec++;
            if (ov_a !== 1'b0 || dn_a !== 1'b0) begin
                nfail++;
                $display("FAIL idle_hold: valid=%b done=%b, want 0/0", ov_a, dn_a);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        for (int t = 0; t < 25; t++)
            run(bit'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 31), 1, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 32'(i * 3);
            mem_b[i] = 32'(i * 5 + 1);
        end
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_clamp();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
